// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
// Size codes follow funct3[1:0]; store lane encoding lives here.
package load_store_unit_pkg;

    localparam logic [1:0] BYTE = 2'b00;
    localparam logic [1:0] HALF = 2'b01;
    localparam logic [1:0] WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } lsuStates;

    function automatic logic isMisaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        return (size == 2'b11)
            || (size == HALF && off[0])
            || (size == WORD && off != 2'b00);
    endfunction

    function automatic logic [3:0] storeBe(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic [3:0] be;
        case (size)
            BYTE:    be = 4'b0001 << off;
            HALF:    be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Lanes are replicated so the byte enables alone pick the target bytes.
    function automatic logic [31:0] storeWdata(
        input logic [1:0]  size,
        input logic [31:0] sd
    );
        logic [31:0] wd;
        case (size)
            BYTE:    wd = {4{sd[7:0]}};
            HALF:    wd = {2{sd[15:0]}};
            default: wd = sd;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Load data alignment: shift the addressed lane down,
// truncate to the access size and sign- or zero-extend.
module load_extend
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] result
);

    logic [31:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        result = shifted;
        unique case (1'b1)
            size == BYTE:
                result = {{24{~uns & shifted[7]}}, shifted[7:0]};
            size == HALF:
                result = {{16{~uns & shifted[15]}}, shifted[15:0]};
            default:
                result = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one req/gnt/rvalid transaction
// per instruction, with stall, fault and timeout reporting.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        exValid,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [1:0]  memSize,
    input  logic        memUnsigned,
    input  logic [31:0] aluOutput,
    input  logic [31:0] storeData,
    output logic        lsuStall,
    output logic        loadValid,
    output logic [31:0] loadData,
    output logic        misaligned,
    output logic        timeout,
    output logic        dmemReq,
    output logic        dmemWe,
    output logic [31:0] dmemAddr,
    output logic [31:0] dmemWdata,
    output logic [3:0]  dmemBe,
    input  logic        dmemGnt,
    input  logic        dmemRvalid,
    input  logic [31:0] dmemRdata
);

    lsuStates    state;
    lsuStates    nextState;
    logic [7:0]  cnt;
    logic [8:0]  cntNext;
    logic        expire;
    logic        access;
    logic        fault;
    logic        accept;
    logic [31:0] addrQ;
    logic [31:0] wdataQ;
    logic [3:0]  beQ;
    logic [1:0]  offQ;
    logic [1:0]  sizeQ;
    logic        unsQ;
    logic        weQ;
    logic        toQ;
    logic [31:0] extData;

    // Combinational outputs are gated by resetN so they read 0 during reset.
    assign access  = exValid & (memRead | memWrite);
    assign fault   = access & isMisaligned(memSize, aluOutput[1:0]);
    assign accept  = resetN & (state == IDLE) & access & ~fault;
    assign cntNext = {1'b0, cnt} + 9'd1;
    assign expire  = cntNext >= 9'(TIMEOUT_CYCLES);

    load_extend u_extend (
        .rdata  (dmemRdata),
        .offset (offQ),
        .size   (sizeQ),
        .uns    (unsQ),
        .result (extData)
    );

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (accept) nextState = REQ;
            REQ: begin
                if (dmemGnt) nextState = weQ ? DONE : WAIT;
                else if (expire) nextState = DONE;
            end
            WAIT: if (dmemRvalid || expire) nextState = DONE;
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            cnt      <= '0;
            addrQ    <= '0;
            wdataQ   <= '0;
            beQ      <= '0;
            offQ     <= '0;
            sizeQ    <= '0;
            unsQ     <= 1'b0;
            weQ      <= 1'b0;
            toQ      <= 1'b0;
            loadData <= '0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: begin
                    if (accept) begin
                        addrQ  <= {aluOutput[31:2], 2'b00};
                        offQ   <= aluOutput[1:0];
                        sizeQ  <= memSize;
                        unsQ   <= memUnsigned;
                        weQ    <= memWrite;
                        beQ    <= memWrite
                                ? storeBe(memSize, aluOutput[1:0])
                                : 4'b1111;
                        wdataQ <= memWrite
                                ? storeWdata(memSize, storeData)
                                : '0;
                        toQ    <= 1'b0;
                        cnt    <= '0;
                    end
                end
                REQ: begin
                    cnt <= cnt + 8'd1;
                    if (!dmemGnt && expire) begin
                        toQ      <= 1'b1;
                        loadData <= '0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (dmemRvalid) begin
                        loadData <= extData;
                    end else if (expire) begin
                        toQ      <= 1'b1;
                        loadData <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign lsuStall   = accept | (state == REQ) | (state == WAIT);
    assign misaligned = resetN & (state == IDLE) & fault;
    assign loadValid  = (state == DONE) & ~weQ & ~toQ;
    assign timeout    = (state == DONE) & toQ;
    assign dmemReq    = (state == REQ);
    assign dmemWe     = dmemReq & weQ;
    assign dmemAddr   = addrQ;
    assign dmemWdata  = wdataQ;
    assign dmemBe     = beQ;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed table, reset and timeout
// sequences, and randomized accesses against a behavioural model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        resetN;
    logic        exValid, memRead, memWrite, memUnsigned;
    logic [1:0]  memSize;
    logic [31:0] aluOutput, storeData;
    logic        dmemGnt, dmemRvalid;
    logic [31:0] dmemRdata;

    logic        stall0, lv0, mis0, to0, req0, we0;
    logic [31:0] ld0, addr0, wd0;
    logic [3:0]  be0;
    logic        stall1, lv1, mis1, to1, req1, we1;
    logic [31:0] ld1, addr1, wd1;
    logic [3:0]  be1;

    logic        oStall, oLv, oMis, oTo, oReq, oWe;
    logic [31:0] oLd, oAddr, oWd;
    logic [3:0]  oBe;
    bit          sel = 1'b0;

    int nChecks = 0;
    int nFail = 0;

    always #5 clk = ~clk;

    load_store_unit u_main (
        .clk(clk), .resetN(resetN), .exValid(exValid),
        .memRead(memRead), .memWrite(memWrite), .memSize(memSize),
        .memUnsigned(memUnsigned), .aluOutput(aluOutput),
        .storeData(storeData), .lsuStall(stall0), .loadValid(lv0),
        .loadData(ld0), .misaligned(mis0), .timeout(to0),
        .dmemReq(req0), .dmemWe(we0), .dmemAddr(addr0),
        .dmemWdata(wd0), .dmemBe(be0), .dmemGnt(dmemGnt),
        .dmemRvalid(dmemRvalid), .dmemRdata(dmemRdata)
    );

    load_store_unit #(.TIMEOUT_CYCLES(4)) u_short (
        .clk(clk), .resetN(resetN), .exValid(exValid),
        .memRead(memRead), .memWrite(memWrite), .memSize(memSize),
        .memUnsigned(memUnsigned), .aluOutput(aluOutput),
        .storeData(storeData), .lsuStall(stall1), .loadValid(lv1),
        .loadData(ld1), .misaligned(mis1), .timeout(to1),
        .dmemReq(req1), .dmemWe(we1), .dmemAddr(addr1),
        .dmemWdata(wd1), .dmemBe(be1), .dmemGnt(dmemGnt),
        .dmemRvalid(dmemRvalid), .dmemRdata(dmemRdata)
    );

    always_comb begin
        oStall = sel ? stall1 : stall0;
        oLv    = sel ? lv1    : lv0;
        oMis   = sel ? mis1   : mis0;
        oTo    = sel ? to1    : to0;
        oReq   = sel ? req1   : req0;
        oWe    = sel ? we1    : we0;
        oLd    = sel ? ld1    : ld0;
        oAddr  = sel ? addr1  : addr0;
        oWd    = sel ? wd1    : wd0;
        oBe    = sel ? be1    : be0;
    end

    typedef struct {
        int stall, mis, to, lv, clash;
        int toCycle, lvCycle, doneCycle;
        int req, we;
        logic [31:0] be, wd, addr, ld, ldAfter;
    } res_t;

    typedef struct {
        int rd, wr, sz, uns;
        logic [31:0] addr, sd, rdata;
        int gd, rv;
        logic [31:0] be, wd, ld;
        int mis, done;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: byte-level arithmetic, not lane muxes.
    function automatic int refFault(int sz, logic [31:0] a);
        if (sz == 3) return 1;
        return ((a % (1 << sz)) != 0) ? 1 : 0;
    endfunction

    function automatic logic [31:0] refBe(int wr, int sz, logic [31:0] a);
        int n;
        if (!wr) return 32'hF;
        n = 1 << sz;
        return 32'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] refWd(int sz, logic [31:0] sd);
        logic [31:0] w;
        int n;
        n = 1 << sz;
        w = '0;
        for (int i = 0; i < 4; i++)
            w[8*i +: 8] = sd[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] refLoad(int sz, int uns,
                                            logic [31:0] a,
                                            logic [31:0] rdata);
        longint v, bits;
        bits = 8 * (1 << sz);
        v = longint'(rdata) >> (8 * (a % 4));
        v = v % (longint'(1) << bits);
        if (!uns && bits < 32 && v >= (longint'(1) << (bits - 1)))
            v = v - (longint'(1) << bits);
        return v[31:0];
    endfunction

    task automatic idleInputs();
        exValid = 0; memRead = 0; memWrite = 0; memSize = 0;
        memUnsigned = 0; aluOutput = 0; storeData = 0;
        dmemGnt = 0; dmemRvalid = 0; dmemRdata = 0;
    endtask

    // One access with a simple memory responder; gd<0 means never grant.
    task automatic run(input int rd, input int wr, input int sz,
                       input int uns, input logic [31:0] addr,
                       input logic [31:0] sd, input logic [31:0] rdata,
                       input int gd, input int rv, output res_t r);
        int reqCnt, gntC;
        bit done;
        r = '{default: 0};
        r.toCycle = -1; r.lvCycle = -1; r.doneCycle = -1;
        reqCnt = 0; gntC = -1; done = 0;
        @(posedge clk); #1;
        exValid = 1; memRead = rd[0]; memWrite = wr[0];
        memSize = 2'(sz); memUnsigned = uns[0];
        aluOutput = addr; storeData = sd; dmemRdata = rdata;
        for (int c = 0; c < 400 && !done; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            dmemGnt = 0; dmemRvalid = 0;
            if (oReq) begin
                if (gd >= 0 && reqCnt == gd) begin
                    dmemGnt = 1; gntC = c;
                end
                reqCnt++;
            end
            if (rd != 0 && gntC >= 0 && c == gntC + rv) dmemRvalid = 1;
            @(negedge clk);
            if (oStall) r.stall++;
            if (oReq) begin
                r.req = 1; r.we = int'(oWe);
                r.be = 32'(oBe); r.wd = oWd; r.addr = oAddr;
            end
            if (oMis) r.mis++;
            if (oTo) begin r.to++; r.toCycle = c; end
            if (oLv) begin r.lv++; r.lvCycle = c; r.ld = oLd; end
            if (int'(oMis) + int'(oTo) + int'(oLv) > 1) r.clash++;
            if (!oStall) begin done = 1; r.doneCycle = c; end
        end
        if (!done) begin
            nChecks++; nFail++;
            $display("FAIL hang: got stall stuck, want completion");
        end
        r.ldAfter = oLd;
        @(posedge clk); #1;
        idleInputs();
    endtask

    task automatic pulseReset();
        @(negedge clk);
        resetN = 0;
        idleInputs();
        #2;
        resetN = 1;
    endtask

    vec_t tbl[12];
    res_t r;

    initial begin
        tbl[0]  = '{0,1,2,0,32'h100,32'hDEADBEEF,32'h0,0,1,
                    32'hF,32'hDEADBEEF,32'h0,0,2};
        tbl[1]  = '{0,1,0,0,32'h103,32'h000000A5,32'h0,0,1,
                    32'h8,32'hA5A5A5A5,32'h0,0,2};
        tbl[2]  = '{1,0,0,0,32'h102,32'h0,32'h00800000,0,1,
                    32'hF,32'h0,32'hFFFFFF80,0,3};
        tbl[3]  = '{1,0,0,1,32'h102,32'h0,32'h00800000,0,1,
                    32'hF,32'h0,32'h00000080,0,3};
        tbl[4]  = '{1,0,1,0,32'h102,32'h0,32'h80010000,0,1,
                    32'hF,32'h0,32'hFFFF8001,0,3};
        tbl[5]  = '{1,0,2,0,32'h101,32'h0,32'h0,0,1,
                    32'h0,32'h0,32'h0,1,0};
        tbl[6]  = '{1,0,3,0,32'h100,32'h0,32'h0,0,1,
                    32'h0,32'h0,32'h0,1,0};
        tbl[7]  = '{1,0,2,0,32'h104,32'h0,32'h12345678,3,2,
                    32'hF,32'h0,32'h12345678,0,7};
        tbl[8]  = '{0,1,1,0,32'h102,32'h1234BEEF,32'h0,1,1,
                    32'hC,32'hBEEFBEEF,32'h0,0,3};
        tbl[9]  = '{1,0,1,1,32'h100,32'h0,32'h7777F00D,0,3,
                    32'hF,32'h0,32'h0000F00D,0,5};
        tbl[10] = '{0,1,1,0,32'h101,32'h5555,32'h0,0,1,
                    32'h0,32'h0,32'h0,1,0};
        tbl[11] = '{1,0,2,1,32'h108,32'h0,32'h80000001,0,1,
                    32'hF,32'h0,32'h80000001,0,3};

        resetN = 0;
        idleInputs();
        #12;
        chk("rst_stall", 32'(stall0), 0);
        chk("rst_req", 32'(req0), 0);
        chk("rst_we", 32'(we0), 0);
        chk("rst_addr", addr0, 0);
        chk("rst_be", 32'(be0), 0);
        chk("rst_wdata", wd0, 0);
        chk("rst_lv", 32'(lv0), 0);
        chk("rst_ld", ld0, 0);
        chk("rst_faults", 32'({mis0, to0}), 0);
        #1 resetN = 1;

        for (int i = 0; i < 12; i++) begin
            vec_t v;
            v = tbl[i];
            run(v.rd, v.wr, v.sz, v.uns, v.addr, v.sd, v.rdata,
                v.gd, v.rv, r);
            chk($sformatf("t%0d_mis", i), 32'(r.mis), 32'(v.mis));
            chk($sformatf("t%0d_done", i), 32'(r.doneCycle), 32'(v.done));
            chk($sformatf("t%0d_stall", i), 32'(r.stall), 32'(v.done));
            chk($sformatf("t%0d_req", i), 32'(r.req), 32'(1 - v.mis));
            chk($sformatf("t%0d_clash", i), 32'(r.clash), 0);
            if (v.mis == 0) begin
                chk($sformatf("t%0d_addr", i), r.addr,
                    {v.addr[31:2], 2'b00});
                chk($sformatf("t%0d_be", i), r.be, v.be);
                chk($sformatf("t%0d_we", i), 32'(r.we), 32'(v.wr));
                if (v.wr != 0) chk($sformatf("t%0d_wd", i), r.wd, v.wd);
                chk($sformatf("t%0d_lv", i), 32'(r.lv), 32'(v.rd));
                if (v.rd != 0) begin
                    chk($sformatf("t%0d_lvcyc", i), 32'(r.lvCycle),
                        32'(v.done));
                    chk($sformatf("t%0d_ld", i), r.ld, v.ld);
                end
            end
        end

        for (int i = 0; i < 120; i++) begin
            int rd, sz, uns, gd, rv, f, dn;
            logic [31:0] a, sd, rdat;
            rd = int'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 3
                 : int'($urandom_range(0, 2));
            uns = int'($urandom_range(0, 1));
            a = $urandom; sd = $urandom; rdat = $urandom;
            gd = int'($urandom_range(0, 4));
            rv = int'($urandom_range(1, 3));
            run(rd, 1 - rd, sz, uns, a, sd, rdat, gd, rv, r);
            f = refFault(sz, a);
            dn = f ? 0 : (rd ? 2 + gd + rv : 2 + gd);
            chk($sformatf("r%0d_mis", i), 32'(r.mis), 32'(f));
            chk($sformatf("r%0d_done", i), 32'(r.doneCycle), 32'(dn));
            chk($sformatf("r%0d_stall", i), 32'(r.stall), 32'(dn));
            chk($sformatf("r%0d_clash", i), 32'(r.clash), 0);
            if (!f) begin
                chk($sformatf("r%0d_addr", i), r.addr, a & ~32'h3);
                chk($sformatf("r%0d_be", i), r.be, refBe(1 - rd, sz, a));
                chk($sformatf("r%0d_lv", i), 32'(r.lv), 32'(rd));
                if (rd) chk($sformatf("r%0d_ld", i), r.ld,
                            refLoad(sz, uns, a, rdat));
                else chk($sformatf("r%0d_wd", i), r.wd, refWd(sz, sd));
            end else begin
                chk($sformatf("r%0d_noreq", i), 32'(r.req), 0);
            end
        end

        // Reset while waiting for a grant.
        @(posedge clk); #1;
        exValid = 1; memRead = 1; memSize = 2'b10; aluOutput = 32'h300;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rreq_req_before", 32'(req0), 1);
        #1 resetN = 0;
        #1;
        chk("rreq_req", 32'(req0), 0);
        chk("rreq_stall", 32'(stall0), 0);
        idleInputs();
        @(negedge clk) resetN = 1;

        // Reset while waiting for read data; late rvalid must be ignored.
        @(posedge clk); #1;
        exValid = 1; memRead = 1; memSize = 2'b10; aluOutput = 32'h300;
        @(posedge clk); #1;
        dmemGnt = 1;
        @(posedge clk); #1;
        dmemGnt = 0;
        @(negedge clk);
        chk("rwait_stall_before", 32'(stall0), 1);
        #1 resetN = 0;
        #1;
        chk("rwait_stall", 32'(stall0), 0);
        chk("rwait_req", 32'(req0), 0);
        idleInputs();
        @(negedge clk) resetN = 1;
        @(posedge clk); #1;
        dmemRvalid = 1; dmemRdata = 32'hBAD0BAD0;
        @(negedge clk);
        chk("late_rv_lv", 32'(lv0), 0);
        chk("late_rv_stall", 32'(stall0), 0);
        @(posedge clk); #1;
        dmemRvalid = 0;
        @(negedge clk);
        chk("late_rv_lv2", 32'(lv0), 0);
        chk("late_rv_ld", ld0, 0);
        run(0, 1, 2, 0, 32'h100, 32'hDEADBEEF, 0, 0, 1, r);
        chk("post_rst_sw_done", 32'(r.doneCycle), 2);
        chk("post_rst_sw_be", r.be, 32'hF);
        chk("post_rst_sw_wd", r.wd, 32'hDEADBEEF);

        // Short-timeout instance.
        pulseReset();
        sel = 1'b1;
        run(1, 0, 2, 0, 32'h10, 0, 32'hCAFEF00D, 0, 1, r);
        chk("to_pre_ld", r.ld, 32'hCAFEF00D);
        chk("to_pre_done", 32'(r.doneCycle), 3);
        run(1, 0, 2, 0, 32'h20, 0, 32'h11111111, -1, 1, r);
        chk("to_pulse", 32'(r.to), 1);
        chk("to_cycle", 32'(r.toCycle), 5);
        chk("to_done", 32'(r.doneCycle), 5);
        chk("to_stall", 32'(r.stall), 5);
        chk("to_lv", 32'(r.lv), 0);
        chk("to_ld", r.ldAfter, 0);
        chk("to_clash", 32'(r.clash), 0);
        pulseReset();
        sel = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit of the pipelined RISC-V core, directly downstream of the execute-stage ALU. It takes the ALU result as the effective address, plus rs2 as store data, and runs one data-memory transaction per instruction over a req/gnt/rvalid handshake. It generates byte enables and replicated write data for stores, and aligns and extends load data. While a transaction is in flight it stalls the pipeline, and it flags misaligned or illegal accesses and memory timeouts.

## Interface
- TIMEOUT_CYCLES, 255: cycles spent in REQ+WAIT before the access is abandoned; legal range 1..255.
- clk  in  1  single clock; all state updates on rising edge.
- resetN  in  1  asynchronous, active-low reset.
- exValid  in  1  EX/MEM register holds a valid instruction.
- memRead / memWrite  in  1 each  load / store; never both high.
- memSize  in  2  funct3[1:0]: 00 byte, 01 half, 10 word, 11 illegal.
- memUnsigned  in  1  funct3[2]; zero-extend loads (LBU/LHU).
- aluOutput  in  32  effective byte address from the ALU.
- storeData  in  32  rs2 value.
- lsuStall  out  1  hold pipeline; EX/MEM inputs stay stable while high.
- loadValid  out  1  one-cycle pulse; loadData valid.
- loadData  out  32  aligned and extended load result.
- misaligned  out  1  one-cycle fault pulse.
- timeout  out  1  one-cycle fault pulse.
- dmemReq, dmemWe  out  1  request / write strobe.
- dmemAddr  out  32  word-aligned address ({addr[31:2],2'b00}).
- dmemWdata  out  32; dmemBe  out  4  write data / byte enables.
- dmemGnt, dmemRvalid  in  1; dmemRdata  in  32.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - An access is an exValid cycle with memRead or memWrite high.
  - If the access is faulting (memSize=11, half with addr[0]=1, or word with addr[1:0]≠0): misaligned=1 for one cycle, no request, lsuStall=0, stay in IDLE.
  - Otherwise latch the address, size, unsigned, we, byte enables and write data, clear the counter, go to REQ.
- REQ: dmemReq=1 with the latched fields held stable until dmemGnt. On dmemGnt, a store goes to DONE and a load goes to WAIT.
- WAIT: on dmemRvalid, capture extended data into loadData and go to DONE.
- DONE: loadValid=1 for loads only, then go to IDLE.
- Counter: increments every REQ/WAIT cycle. When it reaches TIMEOUT_CYCLES, go to DONE with timeout=1, loadValid=0 and loadData=0; dmemReq drops.
- Store encoding (o = addr[1:0]):
  - byte: Be=0001<<o, Wdata={4{sd[7:0]}}.
  - half: Be=0011<<o, Wdata={2{sd[15:0]}}.
  - word: Be=1111, Wdata=sd.
- Loads: dmemBe=1111, dmemWe=0. Result is dmemRdata>>(8·o), truncated to the access size, then sign-extended (memUnsigned=0) or zero-extended (=1). memUnsigned is ignored for word loads.
- lsuStall = (IDLE & valid aligned access) | REQ | WAIT. It is 0 in DONE, so the pipeline advances at the end of the DONE cycle and IDLE sees the next instruction.

## Timing
- Reset: state IDLE, counter 0, every output 0. Assertion mid-transaction forces dmemReq=0 immediately (asynchronous).
- Best-case load is 4 cycles (accept, REQ+gnt, WAIT+rvalid, DONE). Best-case store is 3.
- Memory contract:
  - dmemRvalid arrives at least 1 cycle after the gnt of its request.
  - Exactly one response per load.
  - rvalid outside WAIT is ignored.
  - A response arriving after a timeout is a system error and is not handled.
- Timeout is reached in the same cycle as rvalid: rvalid wins, normal completion.
- Fault pulses and loadValid never coincide.
- Back-to-back accesses: at most one outstanding transaction, and none is accepted in the DONE cycle.

## Structure
- The shared header defaultParameters.svh gains:
  - memSizes constants (BYTE, HALF, WORD);
  - lsuStates enum {IDLE, REQ, WAIT, DONE}.
- Sub-module load_extend: combinational (rdata, offset, size, unsigned) -> 32-bit result. It is instantiated once and unit-testable alone.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, gnt immediate -> dmemBe=1111, Wdata=0xDEADBEEF, Addr=0x100; lsuStall high 2 cycles; DONE on cycle 2.
- SB addr 0x103, data 0x000000A5 -> Be=1000, Wdata=0xA5A5A5A5, Addr=0x100.
- LB 0x102, rdata 0x00800000 -> loadData=0xFFFFFF80. LBU at the same address -> 0x00000080. LH 0x102, rdata 0x8001_0000 -> 0xFFFF8001.
- LW 0x101 -> misaligned pulse, dmemReq stays 0, lsuStall 0. memSize=11 -> misaligned.
- LW with gnt after 3 cycles and rvalid 2 cycles later -> loadValid on cycle 7, lsuStall exactly cycles 0–6. TIMEOUT_CYCLES=4 with no gnt -> timeout pulse on cycle 5, loadData=0.
- resetN low while in WAIT -> dmemReq and lsuStall 0 at once. A later rvalid is ignored; the next SW proceeds normally.
